ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the RAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the RAM word width.
REQ-003 The block SHALL have port i_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1, the reset; synchronous, active-high.
REQ-005 The block SHALL have ports i_req[1:0], i_we[1:0], input, 2 each: per-requester request and write-enable (port 0 processor, port 1 loader/debug).
REQ-006 The block SHALL have ports i_addr_0/i_addr_1, input, ADDR_WIDTH, and i_wdata_0/i_wdata_1, input, DATA_WIDTH, per-requester address and write data.
REQ-007 The block SHALL have port o_ack[1:0], output, 2, a one-cycle completion pulse per requester.
REQ-008 The block SHALL have port o_rdata, output, DATA_WIDTH, read data valid only while the relevant o_ack bit is high.
REQ-009 The block SHALL have ports o_ram_en, output, 1; o_ram_we, output, 1; o_ram_addr, output, ADDR_WIDTH; o_ram_wdata, output, DATA_WIDTH, all registered and forming the RAM-side command.
REQ-010 The block SHALL have port i_ram_rdata, input, DATA_WIDTH: RAM read data, valid the cycle after the o_ram_en cycle.
REQ-011 The block SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ACCESS, RESPOND.
REQ-013 IDLE: if any i_req bit is high, the block SHALL select a winner, register its addr/we/wdata onto the RAM outputs, and enter ACCESS; otherwise it SHALL stay in IDLE.
REQ-014 ACCESS lasts exactly one cycle, with o_ram_en=1 and o_ram_we set to the winner's i_we; the FSM SHALL then enter RESPOND unconditionally.
REQ-015 RESPOND lasts exactly one cycle: o_ram_en=0, o_ack[winner]=1, o_rdata = i_ram_rdata for reads and don't-care for writes; the FSM SHALL then return to IDLE unconditionally.
REQ-016 Latency SHALL be fixed at request sampled in IDLE on cycle N, RAM access on N+1, ack on N+2; peak throughput is one access per 3 cycles.
REQ-017 Arbitration SHALL be round-robin over a 1-bit last-grant register: a single requester wins outright; with both requesting, the port not granted last wins.
REQ-018 The last-grant register SHALL update only on the IDLE->ACCESS transition.
REQ-019 A requester SHALL hold req, we, addr and wdata stable until its ack; the block SHALL sample them only in IDLE.
REQ-020 The block SHALL ignore a request from the just-acked port during the RESPOND cycle; a still-high req is re-arbitrated in the following IDLE cycle as a new access.
REQ-021 A request arriving while busy SHALL wait, with no loss and no ack, until the next IDLE arbitration.
REQ-022 o_ack SHALL be one-hot or zero at all times, and at most one RAM access SHALL be in flight.
REQ-023 When a write is granted, o_ram_wdata SHALL equal the winner's wdata; when a read is granted, o_ram_wdata SHALL be zero.
REQ-024 o_rdata SHALL be zero whenever o_ack is zero.

Reset
REQ-025 On i_reset=1 at a rising edge, the state SHALL become IDLE; o_ack, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata and o_busy SHALL be 0; last-grant SHALL be 1, so port 0 wins the first tie.
REQ-026 Reset in ACCESS or RESPOND SHALL abort the transaction: no ack is issued, and the requester must re-request.
REQ-027 The cycle after reset deasserts SHALL be IDLE and SHALL arbitrate normally.

Verification
REQ-028 Single read: port 0 reads address 0x65, RAM holds 0x0001 -> o_ram_en high on N+1 with addr 0x65; o_ack=01 on N+2 with o_rdata=0x0001.
REQ-029 Single write: port 1 writes 0xBEEF to 0xFF -> ACCESS shows we=1, addr=0xFF, wdata=0xBEEF; o_ack=10 on N+2; a subsequent read of 0xFF returns 0xBEEF.
REQ-030 Contention: both ports hold continuous reads after reset -> grants alternate 0,1,0,1, with acks spaced 3 cycles apart.
REQ-031 Late request: port 1 raises req during port 0's ACCESS -> port 1 receives no ack until port 0's ack; port 1 is granted in the next IDLE and acked 3 cycles later.
REQ-032 Reset mid-op: assert i_reset during ACCESS -> the next cycle has o_ack=00, o_ram_en=0, o_busy=0; the first tie after reset goes to port 0.
REQ-033 Idle hold: no requests for 20 cycles -> o_ram_en, o_ack and o_busy stay 0 throughout.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each granted access walks IDLE -> ACCESS -> RESPOND, so one access is in flight at a time.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [1:0]            i_req,
  input  logic [1:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr_0,
  input  logic [ADDR_WIDTH-1:0] i_addr_1,
  input  logic [DATA_WIDTH-1:0] i_wdata_0,
  input  logic [DATA_WIDTH-1:0] i_wdata_1,
  output logic [1:0]            o_ack,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    win_q, win_d;
  logic                    wr_q, wr_d;
  logic                    en_q, en_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    pick;
  logic                    pick_we;

  // A lone requester wins outright; a tie goes to the port not granted last.
  always_comb begin
    pick = ~last_q;
    if (i_req == 2'b01)      pick = 1'b0;
    else if (i_req == 2'b10) pick = 1'b1;
  end

  assign pick_we = pick ? i_we[1] : i_we[0];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    wr_d    = wr_q;
    en_d    = en_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d = ACCESS;
          win_d   = pick;
          last_d  = pick;
          wr_d    = pick_we;
          en_d    = 1'b1;
          we_d    = pick_we;
          addr_d  = pick ? i_addr_1 : i_addr_0;
          if (pick_we) wdata_d = pick ? i_wdata_1 : i_wdata_0;
          else         wdata_d = '0;
        end
      end
      ACCESS: begin
        state_d = RESPOND;
        en_d    = 1'b0;
        we_d    = 1'b0;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // RAM read data lands in RESPOND; it is only forwarded for reads so idle cycles read as zero.
  assign o_ack       = (state_q == RESPOND) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_rdata     = (state_q == RESPOND && !wr_q) ? i_ram_rdata : '0;
  assign o_ram_en    = en_q;
  assign o_ram_we    = we_q;
  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural RAM, a table of single transactions and
// hand-written contention / late-request / reset sequences, acks checked via a scoreboard.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req, we, ack;
  logic [7:0]  addr0, addr1, ram_addr;
  logic [15:0] wdata0, wdata1, rdata, ram_wdata, ram_rdata;
  logic        ram_en, ram_we, busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [15:0] rd;
  } sb_t;

  sb_t         sbq[$];
  vec_t        vecs[6];
  logic [15:0] mem[256];

  ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_we(we),
    .i_addr_0(addr0), .i_addr_1(addr1), .i_wdata_0(wdata0), .i_wdata_1(wdata1),
    .o_ack(ack), .o_rdata(rdata), .o_ram_en(ram_en), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int a);
    if (a == 'h65) return 16'h0001;
    return 16'hA500 ^ 16'(a * 3);
  endfunction

  // RAM contents are restored on every reset so each sequence starts from known data.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (ram_en === 1'b1) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst === 1'b0) begin
      if (ack !== 2'b00) begin
        if (sbq.size() == 0) check("unexpected_ack", 32'(ack), 32'd0);
        else begin
          e = sbq.pop_front();
          check("ack_port", 32'(ack), e.port ? 32'd2 : 32'd1);
          if (!e.we) check("ack_rdata", 32'(rdata), 32'(e.rd));
        end
      end else begin
        check("rdata_zero_no_ack", 32'(rdata), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge with the DUT in IDLE; returns #1 into the cycle after the ack.
  task automatic do_txn(vec_t v);
    if (v.port) begin
      req[1] = 1'b1; we[1] = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req[0] = 1'b1; we[0] = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    sbq.push_back({v.port, v.we, v.exp});
    @(negedge clk);
    check("txn_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    check("access_en", 32'(ram_en), 32'd1);
    check("access_we", 32'(ram_we), 32'(v.we));
    check("access_addr", 32'(ram_addr), 32'(v.addr));
    check("access_wdata", 32'(ram_wdata), v.we ? 32'(v.wdata) : 32'd0);
    check("access_ack_low", 32'(ack), 32'd0);
    @(posedge clk); @(negedge clk);
    check("respond_en", 32'(ram_en), 32'd0);
    check("respond_ack", 32'(ack), v.port ? 32'd2 : 32'd1);
    check("respond_busy", 32'(busy), 32'd1);
    tick();
    req = 2'b00;
  endtask

  initial begin
    req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    vecs[0] = '{port: 1'b0, we: 1'b0, addr: 8'h65, wdata: 16'h0000, exp: 16'h0001};
    vecs[1] = '{port: 1'b1, we: 1'b1, addr: 8'hFF, wdata: 16'hBEEF, exp: 16'h0000};
    vecs[2] = '{port: 1'b0, we: 1'b0, addr: 8'hFF, wdata: 16'h0000, exp: 16'hBEEF};
    vecs[3] = '{port: 1'b0, we: 1'b1, addr: 8'h00, wdata: 16'h1234, exp: 16'h0000};
    vecs[4] = '{port: 1'b1, we: 1'b0, addr: 8'h00, wdata: 16'h0000, exp: 16'h1234};
    vecs[5] = '{port: 1'b1, we: 1'b0, addr: 8'h65, wdata: 16'hFFFF, exp: 16'h0001};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_en", 32'(ram_en), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_hold", {28'd0, ram_en, ack, busy}, 32'd0);
    end

    // Contention: both ports read continuously, first tie after reset goes to port 0.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    addr0 = 8'h10; addr1 = 8'h20; we = 2'b00; req = 2'b11;
    sbq.push_back({1'b0, 1'b0, init_val('h10)});
    sbq.push_back({1'b1, 1'b0, init_val('h20)});
    sbq.push_back({1'b0, 1'b0, init_val('h10)});
    sbq.push_back({1'b1, 1'b0, init_val('h20)});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("contention_ack_slot", 32'(ack != 2'b00), 32'(k % 3 == 2));
    end
    tick();
    req = 2'b00;

    // Late request: port 1 shows up during port 0's ACCESS cycle.
    addr0 = 8'h65; req[0] = 1'b1;
    sbq.push_back({1'b0, 1'b0, 16'h0001});
    tick();
    addr1 = 8'hFF; req[1] = 1'b1;
    sbq.push_back({1'b1, 1'b0, init_val('hFF)});
    @(negedge clk);
    check("late_ack_n1", 32'(ack), 32'd0);
    @(posedge clk); @(negedge clk);
    check("late_ack_n2", 32'(ack), 32'd1);
    tick();
    req[0] = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      check("late_ack_p1", 32'(ack), (k == 5) ? 32'd2 : 32'd0);
    end
    tick();
    req = 2'b00;

    // Reset during ACCESS aborts the access; the following tie goes to port 0.
    addr0 = 8'h10; addr1 = 8'h20; req[0] = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_access", 32'(ram_en), 32'd1);
    tick();
    rst = 1'b0;
    req = 2'b11;
    sbq.push_back({1'b0, 1'b0, init_val('h10)});
    @(negedge clk);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_en", 32'(ram_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    check("midrst_tie_en", 32'(ram_en), 32'd1);
    check("midrst_tie_addr", 32'(ram_addr), 32'h10);
    @(posedge clk); @(negedge clk);
    check("midrst_tie_ack", 32'(ack), 32'd1);
    tick();
    req = 2'b00;
    repeat (4) tick();

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
